// File: rtl/puerta_auto_param.sv
// Automatic door controller: tick-timed open/hold/close travel with obstacle reversal and fault latch.
// Optional PUERTA_LOCK_EN adds a lock input that suppresses presence (never obstacle) requests.
//   state    | meaning
//   CERRADO  | door closed, motor stopped
//   ABRIENDO | opening travel, motor open
//   ABIERTO  | holding open, motor stopped
//   CERRANDO | closing travel, motor close
//   FALLA    | fault latched after repeated reversals, alarm on
module puerta_auto_param #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int NUM_SENSE = 2,
    parameter int T_TRAVEL  = 3,
    parameter int T_HOLD    = 5,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SENSE-1:0] sense,
    input  logic                 obs,
`ifdef PUERTA_LOCK_EN
    input  logic                 lock,
`endif
    output logic [1:0]           motor,
    output logic                 alarm,
    output logic [2:0]           state,
    output logic                 tick_led
);

    localparam int T_MAX = (T_TRAVEL > T_HOLD) ? T_TRAVEL : T_HOLD;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int RW    = $clog2(MAX_RETRY + 1);
    localparam int CW    = $clog2(TICK_DIV);

    localparam logic [TW-1:0] TRAVEL_LD = TW'(T_TRAVEL);
    localparam logic [TW-1:0] HOLD_LD   = TW'(T_HOLD);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        CERRADO  = 3'b000,
        ABRIENDO = 3'b001,
        ABIERTO  = 3'b010,
        CERRANDO = 3'b011,
        FALLA    = 3'b100
    } state_t;

    logic [NUM_SENSE-1:0] sense_s1_q, sense_s2_q;
    logic                 obs_s1_q, obs_s2_q;
    logic                 lock_s;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic          tick_led_q, tick_led_d;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [RW-1:0] retry_inc;
    logic [1:0]    motor_q, motor_d;
    logic          alarm_q, alarm_d;
    logic          pres, pres_eff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sense_s1_q <= '0;
            sense_s2_q <= '0;
            obs_s1_q   <= 1'b0;
            obs_s2_q   <= 1'b0;
        end else begin
            sense_s1_q <= sense;
            sense_s2_q <= sense_s1_q;
            obs_s1_q   <= obs;
            obs_s2_q   <= obs_s1_q;
        end
    end

`ifdef PUERTA_LOCK_EN
    logic lock_s1_q, lock_s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
        end else begin
            lock_s1_q <= lock;
            lock_s2_q <= lock_s1_q;
        end
    end

    assign lock_s = lock_s2_q;
`else
    assign lock_s = 1'b0;
`endif

    assign pres     = |sense_s2_q;
    assign pres_eff = pres & ~lock_s;

    // Free-running prescaler; FSM state changes never restart it.
    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d      = tick ? '0 : cnt_q + CW'(1);
        tick_led_d = tick_led_q ^ tick;
    end

    assign retry_inc = (retry_q >= RETRY_MAX) ? RETRY_MAX : retry_q + RW'(1);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        case (state_q)
            CERRADO: begin
                if (pres_eff) begin
                    state_d = ABRIENDO;
                    timer_d = TRAVEL_LD;
                end
            end
            ABRIENDO: begin
                if (tick) begin
                    if (timer_q <= TW'(1)) begin
                        state_d = ABIERTO;
                        timer_d = HOLD_LD;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            ABIERTO: begin
                if (pres_eff || obs_s2_q) begin
                    timer_d = HOLD_LD;
                end else if (tick) begin
                    if (timer_q <= TW'(1)) begin
                        state_d = CERRANDO;
                        timer_d = TRAVEL_LD;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            CERRANDO: begin
                // Obstacle outranks presence and the tick; lock never masks it.
                if (obs_s2_q) begin
                    retry_d = retry_inc;
                    if (retry_inc == RETRY_MAX) begin
                        state_d = FALLA;
                    end else begin
                        state_d = ABRIENDO;
                        timer_d = TRAVEL_LD;
                    end
                end else if (pres_eff) begin
                    state_d = ABRIENDO;
                    timer_d = TRAVEL_LD;
                end else if (tick) begin
                    if (timer_q <= TW'(1)) begin
                        state_d = CERRADO;
                        retry_d = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            FALLA: begin
                state_d = FALLA;
            end
            default: begin
                state_d = CERRADO;
                timer_d = '0;
                retry_d = '0;
            end
        endcase
    end

    always_comb begin
        motor_d = 2'b00;
        alarm_d = 1'b0;
        case (state_d)
            ABRIENDO: motor_d = 2'b01;
            CERRANDO: motor_d = 2'b10;
            FALLA:    alarm_d = 1'b1;
            default:  motor_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            tick_led_q <= 1'b0;
            state_q    <= CERRADO;
            timer_q    <= '0;
            retry_q    <= '0;
            motor_q    <= 2'b00;
            alarm_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tick_led_q <= tick_led_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            motor_q    <= motor_d;
            alarm_q    <= alarm_d;
        end
    end

    assign motor    = motor_q;
    assign alarm    = alarm_q;
    assign state    = state_q;
    assign tick_led = tick_led_q;

endmodule

// File: tb/tb_puerta_auto_param.sv
// Directed bench for puerta_auto_param with TICK_DIV=4, T_TRAVEL=2, T_HOLD=3, MAX_RETRY=2.
// Edge counter en counts rising edges since reset release; ticks land on edges where en%4==0.
module tb_puerta_auto_param;

    logic       clk;
    logic       rst;
    logic [1:0] sense;
    logic       obs;
`ifdef PUERTA_LOCK_EN
    logic       lock;
`endif
    logic [1:0] motor;
    logic       alarm;
    logic [2:0] state;
    logic       tick_led;

    int n_vec = 0;
    int n_err = 0;
    int en    = 0;

    puerta_auto_param #(
        .TICK_DIV (4),
        .NUM_SENSE(2),
        .T_TRAVEL (2),
        .T_HOLD   (3),
        .MAX_RETRY(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sense   (sense),
        .obs     (obs),
`ifdef PUERTA_LOCK_EN
        .lock    (lock),
`endif
        .motor   (motor),
        .alarm   (alarm),
        .state   (state),
        .tick_led(tick_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, en);
        end
    endtask

    task automatic step();
        @(posedge clk);
        en++;
        #1;
    endtask

    task automatic step_to(input int n);
        while (en < n) step();
    endtask

    task automatic chk_sm(input string tag, input logic [2:0] st, input logic [1:0] mo);
        chk({tag, "_state"}, {5'd0, state}, {5'd0, st});
        chk({tag, "_motor"}, {6'd0, motor}, {6'd0, mo});
    endtask

    task automatic release_rst();
        step();
        step();
        #2;
        rst = 1'b1;
        en  = 0;
    endtask

    initial begin
        rst   = 1'b0;
        sense = 2'b00;
        obs   = 1'b0;
`ifdef PUERTA_LOCK_EN
        lock  = 1'b0;
`endif
        #20;
        chk_sm("rst", 3'b000, 2'b00);
        chk("rst_alarm", {7'd0, alarm}, 8'd0);
        chk("rst_tick_led", {7'd0, tick_led}, 8'd0);
        chk("rst_retry", {6'd0, dut.retry_q}, 8'd0);
        #2;
        rst = 1'b1;
        en  = 0;

        // full open/hold/close cycle
        step_to(1);
        sense = 2'b01;
        step();
        sense = 2'b00;
        step_to(3);
        chk_sm("lat_e3", 3'b000, 2'b00);
        chk("tled_e3", {7'd0, tick_led}, 8'd0);
        step_to(4);
        chk_sm("open_e4", 3'b001, 2'b01);
        chk("tled_e4", {7'd0, tick_led}, 8'd1);
        step_to(11);
        chk_sm("open_e11", 3'b001, 2'b01);
        step_to(12);
        chk_sm("hold_e12", 3'b010, 2'b00);
        step_to(23);
        chk_sm("hold_e23", 3'b010, 2'b00);
        step_to(24);
        chk_sm("close_e24", 3'b011, 2'b10);
        step_to(31);
        chk_sm("close_e31", 3'b011, 2'b10);
        step_to(32);
        chk_sm("closed_e32", 3'b000, 2'b00);
        chk("retry_e32", {6'd0, dut.retry_q}, 8'd0);

        // hold extension with sense[1] held
        sense = 2'b10;
        step_to(34);
        chk_sm("ext_e34", 3'b000, 2'b00);
        step_to(35);
        chk_sm("ext_e35", 3'b001, 2'b01);
        step_to(40);
        chk_sm("ext_e40", 3'b010, 2'b00);
        for (int i = 0; i < 40; i++) begin
            step();
            chk_sm("ext_hold", 3'b010, 2'b00);
        end
        sense = 2'b00;
        step_to(91);
        chk_sm("ext_e91", 3'b010, 2'b00);
        step_to(92);
        chk_sm("ext_e92", 3'b011, 2'b10);

        // single obstacle reversal, coincident with a tick
        step_to(93);
        obs = 1'b1;
        step();
        obs = 1'b0;
        step_to(95);
        chk_sm("rev_e95", 3'b011, 2'b10);
        step_to(96);
        chk_sm("rev_e96", 3'b001, 2'b01);
        chk("rev_alarm", {7'd0, alarm}, 8'd0);
        chk("rev_retry", {6'd0, dut.retry_q}, 8'd1);
        step_to(104);
        chk_sm("rev_e104", 3'b010, 2'b00);
        step_to(116);
        chk_sm("rev_e116", 3'b011, 2'b10);
        chk("rev_retry_kept", {6'd0, dut.retry_q}, 8'd1);
        step_to(123);
        chk_sm("rev_e123", 3'b011, 2'b10);
        step_to(124);
        chk_sm("rev_e124", 3'b000, 2'b00);
        chk("rev_retry_clr", {6'd0, dut.retry_q}, 8'd0);

        // two reversals in one close attempt -> fault
        sense = 2'b01;
        step();
        sense = 2'b00;
        step_to(127);
        chk_sm("flt_e127", 3'b001, 2'b01);
        step_to(132);
        chk_sm("flt_e132", 3'b010, 2'b00);
        step_to(144);
        chk_sm("flt_e144", 3'b011, 2'b10);
        obs = 1'b1;
        step();
        obs = 1'b0;
        step_to(147);
        chk_sm("flt_e147", 3'b001, 2'b01);
        chk("flt_retry1", {6'd0, dut.retry_q}, 8'd1);
        step_to(164);
        chk_sm("flt_e164", 3'b011, 2'b10);
        obs = 1'b1;
        step();
        obs = 1'b0;
        step_to(166);
        chk_sm("flt_e166", 3'b011, 2'b10);
        step_to(167);
        chk_sm("flt_e167", 3'b100, 2'b00);
        chk("flt_alarm", {7'd0, alarm}, 8'd1);
        sense = 2'b11;
        obs   = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk_sm("flt_absorb", 3'b100, 2'b00);
        chk("flt_absorb_alarm", {7'd0, alarm}, 8'd1);
        sense = 2'b00;
        obs   = 1'b0;
        #4;
        rst = 1'b0;
        #1;
        chk_sm("flt_rst", 3'b000, 2'b00);
        chk("flt_rst_alarm", {7'd0, alarm}, 8'd0);
        release_rst();

        // asynchronous reset during opening travel
        step_to(1);
        sense = 2'b01;
        step();
        sense = 2'b00;
        step_to(6);
        chk_sm("mid_e6", 3'b001, 2'b01);
        chk("mid_tled_e6", {7'd0, tick_led}, 8'd1);
        #3;
        rst = 1'b0;
        #1;
        chk_sm("mid_rst", 3'b000, 2'b00);
        chk("mid_rst_tled", {7'd0, tick_led}, 8'd0);
        chk("mid_rst_alarm", {7'd0, alarm}, 8'd0);
        release_rst();

`ifdef PUERTA_LOCK_EN
        step_to(1);
        lock  = 1'b1;
        sense = 2'b11;
        for (int i = 0; i < 50; i++) begin
            step();
            chk_sm("lock_closed", 3'b000, 2'b00);
        end
        step_to(52);
        lock  = 1'b0;
        sense = 2'b01;
        step();
        sense = 2'b00;
        step_to(55);
        chk_sm("lock_open_e55", 3'b001, 2'b01);
        step_to(60);
        chk_sm("lock_hold_e60", 3'b010, 2'b00);
        lock = 1'b1;
        step_to(72);
        chk_sm("lock_close_e72", 3'b011, 2'b10);
        obs = 1'b1;
        step();
        obs = 1'b0;
        step_to(74);
        chk_sm("lock_obs_e74", 3'b011, 2'b10);
        step_to(75);
        chk_sm("lock_obs_e75", 3'b001, 2'b01);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
